// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: shared states, bit phases and constants for the I2C register master.
package i2c_master_pkg;
    typedef enum logic [3:0] {IDLE, START, DEVW, REGA, WDATA, RSTART, DEVR, RDATA, STOP} state_t;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ = 1'b1;
    localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: quarter-bit divider and phase counter, held cleared while idle.
module i2c_bit_timer
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DIV_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       qtick,
    output logic [1:0] phase
);
    logic [DIV_W-1:0] div;

    assign qtick = en && div == DIV_W'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            phase <= Q0;
        end else if (!en) begin
            div <= '0;
            phase <= Q0;
        end else if (qtick) begin
            div <= '0;
            phase <= phase + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-byte I2C register write/read initiator driving open-drain SCL/SDA enables.
module i2c_reg_master
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DIV_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);
    state_t state, state_n;
    logic qtick, q_end, fin, is_byte, ack_slot, tx_bit;
    logic [1:0] phase;
    logic [3:0] cnt;
    logic rw_q;
    logic [6:0] dev_q, sr;
    logic [7:0] reg_q, wd_q, tx;

    i2c_bit_timer #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_timer (
        .clk(clk),
        .reset(reset),
        .en(busy),
        .qtick(qtick),
        .phase(phase)
    );

    always_comb begin
        state_n = state;
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        is_byte = state inside {DEVW, REGA, WDATA, DEVR, RDATA};
        ack_slot = cnt == 4'(BITS_PER_BYTE);
        q_end = qtick && phase == Q3;
        fin = state == STOP && q_end;
        // 8'hFF keeps SDA released for read data bits
        tx = state == DEVW ? {dev_q, 1'b0} : state == REGA ? reg_q : state == WDATA ? wd_q :
             state == DEVR ? {dev_q, 1'b1} : 8'hFF;
        tx_bit = ack_slot || tx[3'd7 - cnt[2:0]];
        case (state)
            IDLE: state_n = start ? START : IDLE;
            START, RSTART: begin
                scl_oe = (state == RSTART && phase == Q0) || phase == Q3;
                sda_oe = phase != Q0 && phase != Q1;
                if (q_end) state_n = state == START ? DEVW : DEVR;
            end
            STOP: begin
                scl_oe = phase == Q0;
                sda_oe = phase != Q3;
                if (q_end) state_n = IDLE;
            end
            default: begin
                scl_oe = phase == Q0 || phase == Q3;
                sda_oe = !tx_bit;
                if (q_end && ack_slot)
                    state_n = (ack_err || state == RDATA || state == WDATA) ? STOP :
                              state == DEVW ? REGA : state == DEVR ? RDATA :
                              rw_q == RW_WRITE ? WDATA : RSTART;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            ack_err <= 1'b0;
            rd_data <= '0;
            sr <= '0;
            rw_q <= RW_WRITE;
            dev_q <= '0;
            reg_q <= '0;
            wd_q <= '0;
        end else begin
            state <= state_n;
            done <= fin;
            if (start && !busy) begin
                busy <= 1'b1;
                ack_err <= 1'b0;
                rw_q <= rw;
                dev_q <= dev_addr;
                reg_q <= reg_addr;
                wd_q <= wr_data;
            end else if (fin) begin
                busy <= 1'b0;
            end
            if (is_byte && q_end) cnt <= ack_slot ? 4'd0 : cnt + 4'd1;
            if (is_byte && qtick && phase == Q2) begin
                if (ack_slot && state != RDATA && sda_i) ack_err <= 1'b1;
                if (!ack_slot && state == RDATA) begin
                    sr <= {sr[5:0], sda_i};
                    if (cnt == 4'd7) rd_data <= {sr, sda_i};
                end
            end
        end
    end
endmodule
